alu16_sequencer: RTL and testbench

// - Drives the 8-bit combinational alu to execute 16-bit ADD/SUB (ADD HL,rr / SBC-class paths).
// - Splits each op into low-byte, high-byte and optional carry-fix passes and chains carry in the FSM.
// - Sits between the instruction execute stage (valid/ready request and response) and one alu instance.

---
 rtl/alu16_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu16_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_sequencer.sv
// Sequences one 8-bit ALU through low, high and optional carry-fix passes to produce 16-bit ADD/SUB.
// Define ALU16_FLAGS_EXT_EN to report S and Z in rsp_flags[7:6]; otherwise those bits read zero.
module alu16_sequencer #(
   parameter int          W_HALF      = 8,
   parameter logic [4:0]  OP_ADD_CODE = 5'b00000,
   parameter logic [4:0]  OP_SUB_CODE = 5'b00001,
   parameter logic [4:0]  OP_INC_CODE = 5'b01100,
   parameter logic [4:0]  OP_DEC_CODE = 5'b01101
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_op,
   input  logic [2*W_HALF-1:0]   i_req_a,
   input  logic [2*W_HALF-1:0]   i_req_b,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [2*W_HALF-1:0]   o_rsp_result,
   output logic [7:0]            o_rsp_flags,
   output logic [W_HALF-1:0]     o_alu_a,
   output logic [W_HALF-1:0]     o_alu_b,
   output logic [4:0]            o_alu_opcode,
   input  logic [W_HALF-1:0]     i_alu_out,
   input  logic [7:0]            i_alu_flags
);

   localparam int W_FULL = 2 * W_HALF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_FIX,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [W_FULL-1:0]   r_a;
   logic [W_FULL-1:0]   r_b;
   logic                r_op;
   logic [W_FULL-1:0]   r_res;
   logic                r_c_lo;
   logic                r_c_hi;
   logic [7:0]          r_flags;

   logic [4:0]          w_arith_code;
   logic [W_HALF-1:0]   w_hi_pre;
   logic                w_c_hi;
   logic                w_hi_wrap;
   logic                w_carry;
   logic [W_FULL-1:0]   w_final;
   logic                w_pv;
   logic [7:0]          w_flags;
   logic                w_unused_flags;

   assign w_unused_flags = ^i_alu_flags[7:1];
   assign w_arith_code   = r_op ? OP_SUB_CODE : OP_ADD_CODE;

   // Final flags are formed from whichever pass writes the last high byte (HI or FIX).
   assign w_hi_pre  = (r_state == S_FIX) ? r_res[W_FULL-1 -: W_HALF] : i_alu_out;
   assign w_c_hi    = (r_state == S_FIX) ? r_c_hi : i_alu_flags[0];
   assign w_hi_wrap = r_op ? (w_hi_pre == {W_HALF{1'b0}}) : (w_hi_pre == {W_HALF{1'b1}});
   assign w_carry   = w_c_hi | (r_c_lo & w_hi_wrap);
   assign w_final   = {i_alu_out, r_res[W_HALF-1:0]};
   assign w_pv      = r_op ? ((r_a[W_FULL-1] != r_b[W_FULL-1]) && (w_final[W_FULL-1] != r_a[W_FULL-1]))
                           : ((r_a[W_FULL-1] == r_b[W_FULL-1]) && (w_final[W_FULL-1] != r_a[W_FULL-1]));

`ifdef ALU16_FLAGS_EXT_EN
   assign w_flags = {w_final[W_FULL-1], (w_final == {W_FULL{1'b0}}), 3'b000, w_pv, r_op, w_carry};
`else
   assign w_flags = {5'b00000, w_pv, r_op, w_carry};
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 1'b0;
         r_res   <= '0;
         r_c_lo  <= 1'b0;
         r_c_hi  <= 1'b0;
         r_flags <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_a  <= i_req_a;
                  r_b  <= i_req_b;
                  r_op <= i_req_op;
               end
            end
            S_LO: begin
               r_res[W_HALF-1:0] <= i_alu_out;
               r_c_lo            <= i_alu_flags[0];
            end
            S_HI: begin
               r_res[W_FULL-1 -: W_HALF] <= i_alu_out;
               r_c_hi                    <= i_alu_flags[0];
               if (!r_c_lo) begin
                  r_flags <= w_flags;
               end
            end
            S_FIX: begin
               r_res[W_FULL-1 -: W_HALF] <= i_alu_out;
               r_flags                   <= w_flags;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_next       = r_state;
      o_alu_a      = '0;
      o_alu_b      = '0;
      o_alu_opcode = OP_ADD_CODE;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_next = S_LO;
            end
         end
         S_LO: begin
            o_alu_a      = r_a[W_HALF-1:0];
            o_alu_b      = r_b[W_HALF-1:0];
            o_alu_opcode = w_arith_code;
            w_next       = S_HI;
         end
         S_HI: begin
            o_alu_a      = r_a[W_FULL-1 -: W_HALF];
            o_alu_b      = r_b[W_FULL-1 -: W_HALF];
            o_alu_opcode = w_arith_code;
            w_next       = r_c_lo ? S_FIX : S_DONE;
         end
         S_FIX: begin
            // Propagate the low-byte carry/borrow into the high byte.
            o_alu_a      = r_res[W_FULL-1 -: W_HALF];
            o_alu_opcode = r_op ? OP_DEC_CODE : OP_INC_CODE;
            w_next       = S_DONE;
         end
         S_DONE: begin
            if (i_rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign o_req_ready  = (r_state == S_IDLE);
   assign o_rsp_valid  = (r_state == S_DONE);
   assign o_rsp_result = r_res;
   assign o_rsp_flags  = r_flags;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer with a behavioural 8-bit ALU and a result scoreboard.
// Honours ALU16_FLAGS_EXT_EN the same way as the design.
module tb_alu16_sequencer;

   localparam logic [4:0] ADD_C = 5'b00000;
   localparam logic [4:0] SUB_C = 5'b00001;
   localparam logic [4:0] INC_C = 5'b01100;
   localparam logic [4:0] DEC_C = 5'b01101;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqOp;
   logic [15:0] reqA;
   logic [15:0] reqB;
   logic        rspValid;
   logic        rspReady;
   logic [15:0] rspResult;
   logic [7:0]  rspFlags;
   logic [7:0]  aluA;
   logic [7:0]  aluB;
   logic [4:0]  aluOpcode;
   logic [7:0]  aluOut;
   logic [7:0]  aluFlags;

   typedef struct {
      logic [15:0] res;
      logic [7:0]  flags;
      int          lat;
   } exp_t;

   exp_t sbQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   alu16_sequencer dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (reqValid),
      .o_req_ready  (reqReady),
      .i_req_op     (reqOp),
      .i_req_a      (reqA),
      .i_req_b      (reqB),
      .o_rsp_valid  (rspValid),
      .i_rsp_ready  (rspReady),
      .o_rsp_result (rspResult),
      .o_rsp_flags  (rspFlags),
      .o_alu_a      (aluA),
      .o_alu_b      (aluB),
      .o_alu_opcode (aluOpcode),
      .i_alu_out    (aluOut),
      .i_alu_flags  (aluFlags)
   );

   // Behavioural 8-bit ALU; only the carry/borrow in bit 0 matters to the sequencer.
   always_comb begin
      logic [8:0] t;
      t        = '0;
      aluOut   = '0;
      aluFlags = '0;
      case (aluOpcode)
         ADD_C: begin
            t           = {1'b0, aluA} + {1'b0, aluB};
            aluOut      = t[7:0];
            aluFlags[0] = t[8];
         end
         SUB_C: begin
            aluOut      = aluA - aluB;
            aluFlags[0] = (aluA < aluB);
         end
         INC_C: begin
            t           = {1'b0, aluA} + 9'd1;
            aluOut      = t[7:0];
            aluFlags[0] = t[8];
         end
         DEC_C: begin
            aluOut      = aluA - 8'd1;
            aluFlags[0] = (aluA == 8'd0);
         end
         default: begin
         end
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b);
      exp_t       e;
      logic [16:0] s;
      logic       c, pv, fix;
      if (!op) begin
         s   = {1'b0, a} + {1'b0, b};
         c   = s[16];
         pv  = (a[15] == b[15]) && (s[15] != a[15]);
         fix = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
      end else begin
         s   = {1'b0, a - b};
         c   = (a < b);
         pv  = (a[15] != b[15]) && (s[15] != a[15]);
         fix = (a[7:0] < b[7:0]);
      end
      e.res = s[15:0];
`ifdef ALU16_FLAGS_EXT_EN
      e.flags = {s[15], (s[15:0] == 16'h0000), 3'b000, pv, op, c};
`else
      e.flags = {5'b00000, pv, op, c};
`endif
      e.lat = fix ? 4 : 3;
      return e;
   endfunction

   // Drives one request, follows it through the passes, and optionally stalls the response.
   task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                                input int stallCycles);
      exp_t e;
      exp_t got;
      int   cycles;
      e = model(op, a, b);
      sbQ.push_back(e);
      cycles = 0;
      while (!reqReady && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("reqReadyBeforeAccept", reqReady, 1);
      reqValid = 1'b1;
      reqOp    = op;
      reqA     = a;
      reqB     = b;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      reqOp    = ~op;
      reqA     = ~a;
      reqB     = ~b;
      cycles = 1;
      checkOutput("aluLoA", aluA, a[7:0]);
      checkOutput("aluLoB", aluB, b[7:0]);
      checkOutput("aluLoOp", aluOpcode, op ? SUB_C : ADD_C);
      @(negedge clk);
      cycles = 2;
      checkOutput("aluHiA", aluA, a[15:8]);
      checkOutput("aluHiB", aluB, b[15:8]);
      while (!rspValid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      got = sbQ.pop_front();
      checkOutput("latency", cycles, got.lat);
      checkOutput("result", rspResult, got.res);
      checkOutput("flags", rspFlags, got.flags);
      for (int i = 0; i < stallCycles; i++) begin
         reqValid = 1'b1;
         reqOp    = 1'b1;
         reqA     = 16'hAAAA;
         reqB     = 16'h5555;
         @(negedge clk);
         checkOutput("stallValid", rspValid, 1);
         checkOutput("stallResult", rspResult, got.res);
         checkOutput("stallFlags", rspFlags, got.flags);
         checkOutput("stallReqReady", reqReady, 0);
      end
      reqValid = 1'b0;
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
      checkOutput("rspDrop", rspValid, 0);
      checkOutput("readyBack", reqReady, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      reqValid = 1'b0;
      reqOp    = 1'b0;
      reqA     = '0;
      reqB     = '0;
      rspReady = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstReqReady", reqReady, 1);
      checkOutput("rstRspValid", rspValid, 0);
      checkOutput("rstResult", rspResult, 0);
      checkOutput("rstFlags", rspFlags, 0);
      checkOutput("rstAluA", aluA, 0);
      checkOutput("rstAluB", aluB, 0);
      checkOutput("rstAluOp", aluOpcode, ADD_C);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 16'h1234, 16'h0101, 0);
      applyStimulus(1'b0, 16'h00FF, 16'h0001, 0);
      applyStimulus(1'b0, 16'hFFFF, 16'h0001, 0);
      applyStimulus(1'b1, 16'h0000, 16'h0001, 0);
      applyStimulus(1'b0, 16'h7FFF, 16'h0001, 0);
      applyStimulus(1'b1, 16'h8000, 16'h0001, 0);
      applyStimulus(1'b1, 16'h0100, 16'h0001, 0);
      checkOutput("idleAluA", aluA, 0);
      checkOutput("idleAluOp", aluOpcode, ADD_C);

      // Stalled response with a competing request that must be ignored.
      applyStimulus(1'b0, 16'h4321, 16'h1111, 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("noGhostRsp", rspValid, 0);
      end

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0);
      end

      // Reset while the high-byte pass is in progress.
      reqValid = 1'b1;
      reqOp    = 1'b0;
      reqA     = 16'h12FF;
      reqB     = 16'h3401;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("inHiAluA", aluA, 8'h12);
      rst = 1'b1;
      #1;
      checkOutput("midRstReqReady", reqReady, 1);
      checkOutput("midRstRspValid", rspValid, 0);
      checkOutput("midRstResult", rspResult, 0);
      checkOutput("midRstAluA", aluA, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("postRstNoRsp", rspValid, 0);
      end
      applyStimulus(1'b0, 16'h0001, 16'h0001, 0);
      checkOutput("scoreboardEmpty", sbQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
